// File: rtl/fetch_stage.sv
// Instruction-fetch stage: drives the ROM address from the PC, captures the returned
// word into opcode/operand, hands it to the decoder and pulses the PC increment/load.
module fetch_stage #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned OPC_W  = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [ADDR_W-1:0]   pc_in,
    output logic                pc_en,
    output logic                pc_load,
    output logic [ADDR_W-1:0]   pc_bload,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [DATA_W-1:0]   rom_data,
    output logic [OPC_W-1:0]    instr,
    output logic [DATA_W-OPC_W-1:0] oprnd,
    output logic                instr_valid,
    input  logic                instr_ack,
    input  logic                jump_req,
    input  logic [ADDR_W-1:0]   jump_addr,
    output logic [CNT_W-1:0]    fetch_count
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        CAPT,
        VALID,
        LOAD
    } state_e;

    state_e                   state_q, state_d;
    logic                     pc_en_q;
    logic                     pc_load_q;
    logic [ADDR_W-1:0]        pc_bload_q;
    logic [OPC_W-1:0]         instr_q;
    logic [DATA_W-OPC_W-1:0]  oprnd_q;
    logic                     valid_q;
    logic [CNT_W-1:0]         count_q;
    logic                     jump_take;

    assign rom_addr = pc_in;

    // A redirect is honoured in ADDR, CAPT and VALID; it outranks the decoder ack.
    assign jump_take = jump_req && (state_q != IDLE) && (state_q != LOAD);

    always_comb begin
        state_d = state_q;
        if (jump_take) begin
            state_d = LOAD;
        end else begin
            case (state_q)
                IDLE:    if (enable) state_d = ADDR;
                ADDR:    state_d = CAPT;
                CAPT:    state_d = VALID;
                VALID:   if (instr_ack) state_d = enable ? ADDR : IDLE;
                LOAD:    state_d = ADDR;
                default: state_d = IDLE;
            endcase
        end
    end

    // Strobes are registered from the next state so each lines up with its state cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pc_en_q    <= 1'b0;
            pc_load_q  <= 1'b0;
            pc_bload_q <= '0;
            instr_q    <= '0;
            oprnd_q    <= '0;
            valid_q    <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_en_q   <= (state_d == CAPT);
            pc_load_q <= (state_d == LOAD);
            valid_q   <= (state_d == VALID);
            if (jump_take) begin
                pc_bload_q <= jump_addr;
            end
            if (state_q == CAPT) begin
                instr_q <= rom_data[DATA_W-1:DATA_W-OPC_W];
                oprnd_q <= rom_data[DATA_W-OPC_W-1:0];
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign pc_en       = pc_en_q;
    assign pc_load     = pc_load_q;
    assign pc_bload    = pc_bload_q;
    assign instr       = instr_q;
    assign oprnd       = oprnd_q;
    assign instr_valid = valid_q;
    assign fetch_count = count_q;

endmodule
